// File: rtl/elevator_car.sv
// rtl/elevator_car.sv - car/motor model: one-floor hops, arrival stops, door dwell with hold
module elevator_car #(
  parameter int NUM_FLOORS    = 8,
  parameter int FLOOR_W       = 3,
  parameter int TRAVEL_CYCLES = 16,
  parameter int DOOR_CYCLES   = 32,
  parameter int CNT_W         = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  should_move,
  input  logic                  direction,
  input  logic [NUM_FLOORS-1:0] call_all,
  input  logic                  door_hold,
  output logic [FLOOR_W-1:0]    cur_floor,
  output logic                  floor_reached,
  output logic                  door_open,
  output logic                  moving,
  output logic                  move_dir,
  output logic                  limit_err
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_MOVING = 2'd1;
  localparam logic [1:0] S_ARRIVE = 2'd2;
  localparam logic [1:0] S_DOOR   = 2'd3;

  localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(NUM_FLOORS - 1);
  localparam logic [CNT_W-1:0]   TRAVEL_LOAD = CNT_W'(TRAVEL_CYCLES - 1);
  localparam logic [CNT_W-1:0]   DOOR_LOAD   = CNT_W'(DOOR_CYCLES - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] timer;
  logic             call_here;
  logic             can_go;

  assign call_here = call_all[cur_floor];
  // A neighbouring floor exists in the requested direction.
  assign can_go    = direction ? (cur_floor != TOP_FLOOR) : (cur_floor != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      timer         <= '0;
      cur_floor     <= '0;
      floor_reached <= 1'b0;
      door_open     <= 1'b0;
      moving        <= 1'b0;
      move_dir      <= 1'b0;
      limit_err     <= 1'b0;
    end else begin
      limit_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (call_here) begin
            state         <= S_DOOR;
            timer         <= DOOR_LOAD;
            door_open     <= 1'b1;
            floor_reached <= 1'b1;
          end else if (should_move && can_go) begin
            state    <= S_MOVING;
            moving   <= 1'b1;
            move_dir <= direction;
            timer    <= TRAVEL_LOAD;
          end else if (should_move) begin
            limit_err <= 1'b1;
          end
        end
        S_MOVING: begin
          if (timer == '0) begin
            cur_floor <= move_dir ? cur_floor + FLOOR_W'(1) : cur_floor - FLOOR_W'(1);
            state     <= S_ARRIVE;
            moving    <= 1'b0;
          end else begin
            timer <= timer - CNT_W'(1);
          end
        end
        S_ARRIVE: begin
          // Continue only in the same direction; reversals settle in IDLE first.
          if (call_here) begin
            state         <= S_DOOR;
            timer         <= DOOR_LOAD;
            door_open     <= 1'b1;
            floor_reached <= 1'b1;
          end else if (should_move && (direction == move_dir) && can_go) begin
            state  <= S_MOVING;
            moving <= 1'b1;
            timer  <= TRAVEL_LOAD;
          end else begin
            state <= S_IDLE;
          end
        end
        S_DOOR: begin
          if (door_hold) begin
            timer <= DOOR_LOAD;
          end else if (timer == '0) begin
            state         <= S_IDLE;
            door_open     <= 1'b0;
            floor_reached <= 1'b0;
          end else begin
            timer <= timer - CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_elevator_car.sv
// tb/tb_elevator_car.sv - scoreboard bench: expected car events queued, monitor pops and compares
module tb_elevator_car;

  logic       clk = 1'b0;
  logic       reset;
  logic       should_move;
  logic       direction;
  logic [7:0] call_all;
  logic       door_hold;
  logic [2:0] cur_floor;
  logic       floor_reached;
  logic       door_open;
  logic       moving;
  logic       move_dir;
  logic       limit_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // kind: 0 move start (val=floor*2+dir), 1 floor change, 2 door open, 3 door close, 4 limit pulse
  typedef struct {
    int kind;
    int val;
    int cyc;
  } ev_t;
  ev_t exp_q[$];

  elevator_car dut (
    .clk(clk), .reset(reset), .should_move(should_move), .direction(direction),
    .call_all(call_all), .door_hold(door_hold), .cur_floor(cur_floor),
    .floor_reached(floor_reached), .door_open(door_open), .moving(moving),
    .move_dir(move_dir), .limit_err(limit_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_ev(input int kind, input int val, input int at);
    exp_q.push_back('{kind, val, at});
  endtask

  task automatic ev(input int kind, input int val);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_event act=kind%0d/val%0d@%0d exp=none", kind, val, cyc);
    end else begin
      e = exp_q.pop_front();
      chk($sformatf("event_kind@%0d", cyc), kind, e.kind);
      chk($sformatf("event_val@%0d", cyc), val, e.val);
      chk($sformatf("event_cycle_kind%0d", kind), cyc, e.cyc);
      if (kind == 2) chk("floor_reached_on_open", int'(floor_reached), 1);
      if (kind == 3) chk("floor_reached_on_close", int'(floor_reached), 0);
    end
  endtask

  task automatic monitor();
    logic [2:0] pf;
    logic       pm;
    logic       pd;
    pf = '0;
    pm = 1'b0;
    pd = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (moving && !pm)      ev(0, int'(cur_floor) * 2 + int'(move_dir));
        if (cur_floor != pf)    ev(1, int'(cur_floor));
        if (door_open && !pd)   ev(2, int'(cur_floor));
        if (!door_open && pd)   ev(3, int'(cur_floor));
        if (limit_err)          ev(4, int'(cur_floor));
        if (floor_reached)      call_all[cur_floor] = 1'b0;
      end
      pf = cur_floor;
      pm = moving;
      pd = door_open;
    end
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < budget) begin
      tick(1);
      k++;
    end
    chk("pending_events_after_wait", exp_q.size(), 0);
    exp_q.delete();
    tick(4);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_cur_floor"}, int'(cur_floor), 0);
    chk({tag, "_moving"}, int'(moving), 0);
    chk({tag, "_door_open"}, int'(door_open), 0);
    chk({tag, "_floor_reached"}, int'(floor_reached), 0);
    chk({tag, "_move_dir"}, int'(move_dir), 0);
    chk({tag, "_limit_err"}, int'(limit_err), 0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #2 reset = 1'b0;
    #1 check_idle_outputs(tag);
    @(negedge clk);
    #2 reset = 1'b1;
  endtask

  // Hop sequence: move start at s+1+17*(h-1), floor change at s+17*h,
  // door opens one cycle after the final arrival, closes 32 (+hold) cycles later.
  task automatic travel(input int start, input bit dir, input int n, input int hold);
    int s;
    int f;
    int d;
    int k;
    s = cyc;
    f = start;
    for (int h = 1; h <= n; h++) begin
      expect_ev(0, f * 2 + int'(dir), s + 1 + 17 * (h - 1));
      f = dir ? f + 1 : f - 1;
      expect_ev(1, f, s + 17 * h);
    end
    d = s + 17 * n + 1;
    expect_ev(2, f, d);
    expect_ev(3, f, d + 32 + hold);
    should_move = 1'b1;
    direction = dir;
    call_all = 8'h00;
    call_all[f] = 1'b1;
    k = 0;
    while (!door_open && k < 300) begin
      tick(1);
      k++;
    end
    chk("door_open_reached", int'(door_open), 1);
    should_move = 1'b0;
    door_hold = (hold > 0);
    tick(hold);
    door_hold = 1'b0;
    drain(200);
  endtask

  task automatic limit_pulse(input int floor, input bit dir);
    int s;
    s = cyc;
    expect_ev(4, floor, s + 1);
    should_move = 1'b1;
    direction = dir;
    call_all = 8'h00;
    tick(1);
    should_move = 1'b0;
    drain(20);
    chk("limit_floor_held", int'(cur_floor), floor);
  endtask

  initial begin
    int s;
    reset = 1'b0;
    should_move = 1'b0;
    direction = 1'b0;
    call_all = 8'h00;
    door_hold = 1'b0;
    fork
      monitor();
    join_none
    #3 check_idle_outputs("reset_initial");
    @(negedge clk);
    #2 reset = 1'b1;
    tick(2);

    travel(0, 1'b1, 1, 0);
    do_reset("reset_after_hop");
    tick(2);
    travel(0, 1'b1, 3, 0);

    s = cyc;
    expect_ev(0, 3 * 2 + 1, s + 1);
    should_move = 1'b1;
    direction = 1'b1;
    call_all = 8'h00;
    tick(6);
    should_move = 1'b0;
    chk("mid_travel_moving", int'(moving), 1);
    chk("mid_travel_dir", int'(move_dir), 1);
    chk("mid_travel_floor", int'(cur_floor), 3);
    chk("mid_travel_events", exp_q.size(), 0);
    exp_q.delete();
    do_reset("reset_mid_travel");
    tick(20);

    limit_pulse(0, 1'b0);
    travel(0, 1'b1, 7, 0);
    limit_pulse(7, 1'b1);
    travel(7, 1'b0, 5, 50);
    travel(2, 1'b1, 2, 0);
    travel(4, 1'b1, 0, 0);

    chk("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout act=%0d exp=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
